// File: rtl/sc_max7219_rx_if.sv
// sc_max7219_rx_if: serial pins, readback port and decoded status of sc_max7219_rx.
// The dout signal exists only when SC_MAX7219RX_DOUT_EN is defined.
interface sc_max7219_rx_if #(
   parameter int DATAWIDTH_BUS = 8
);
   logic                     SC_MAX7219RX_din_In;
   logic                     SC_MAX7219RX_ncs_In;
   logic                     SC_MAX7219RX_sclk_In;
   logic [2:0]               SC_MAX7219RX_rdAddr_In;
   logic [DATAWIDTH_BUS-1:0] SC_MAX7219RX_rdData_Out;
   logic [3:0]               SC_MAX7219RX_intensity_Out;
   logic [2:0]               SC_MAX7219RX_scanLimit_Out;
   logic [7:0]               SC_MAX7219RX_decodeMode_Out;
   logic                     SC_MAX7219RX_shutdown_Out;
   logic                     SC_MAX7219RX_displayTest_Out;
   logic                     SC_MAX7219RX_frameValid_Out;
   logic [3:0]               SC_MAX7219RX_frameAddr_Out;
   logic [7:0]               SC_MAX7219RX_frameData_Out;
   logic                     SC_MAX7219RX_frameError_Out;
`ifdef SC_MAX7219RX_DOUT_EN
   logic                     SC_MAX7219RX_dout_Out;
`endif

   modport master (
      output SC_MAX7219RX_din_In, SC_MAX7219RX_ncs_In, SC_MAX7219RX_sclk_In,
             SC_MAX7219RX_rdAddr_In,
      input  SC_MAX7219RX_rdData_Out, SC_MAX7219RX_intensity_Out,
             SC_MAX7219RX_scanLimit_Out, SC_MAX7219RX_decodeMode_Out,
             SC_MAX7219RX_shutdown_Out, SC_MAX7219RX_displayTest_Out,
             SC_MAX7219RX_frameValid_Out, SC_MAX7219RX_frameAddr_Out,
             SC_MAX7219RX_frameData_Out, SC_MAX7219RX_frameError_Out
`ifdef SC_MAX7219RX_DOUT_EN
      , input SC_MAX7219RX_dout_Out
`endif
   );

   modport slave (
      input  SC_MAX7219RX_din_In, SC_MAX7219RX_ncs_In, SC_MAX7219RX_sclk_In,
             SC_MAX7219RX_rdAddr_In,
      output SC_MAX7219RX_rdData_Out, SC_MAX7219RX_intensity_Out,
             SC_MAX7219RX_scanLimit_Out, SC_MAX7219RX_decodeMode_Out,
             SC_MAX7219RX_shutdown_Out, SC_MAX7219RX_displayTest_Out,
             SC_MAX7219RX_frameValid_Out, SC_MAX7219RX_frameAddr_Out,
             SC_MAX7219RX_frameData_Out, SC_MAX7219RX_frameError_Out
`ifdef SC_MAX7219RX_DOUT_EN
      , output SC_MAX7219RX_dout_Out
`endif
   );
endinterface

// File: rtl/sc_max7219_rx.sv
// sc_max7219_rx: oversampled MAX7219-compatible serial receiver with readback register file.
// Define SC_MAX7219RX_DOUT_EN to add the daisy-chain serial output SC_MAX7219RX_dout_Out.
module sc_max7219_rx #(
   parameter int DATAWIDTH_BUS = 8,
   parameter int SYNC_STAGES   = 2,
   parameter int FRAME_BITS    = 16
) (
   input  logic           SC_MAX7219RX_CLOCK_50,
   input  logic           SC_MAX7219RX_RESET_InHigh,
   sc_max7219_rx_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   // Frame bits 15:12 are don't-care, so only the pass-through build needs the full window.
`ifdef SC_MAX7219RX_DOUT_EN
   localparam int SR_W = FRAME_BITS;
`else
   localparam int SR_W = FRAME_BITS - 4;
`endif

   logic [SYNC_STAGES-1:0]   din_sync_q, din_sync_d;
   logic [SYNC_STAGES-1:0]   ncs_sync_q, ncs_sync_d;
   logic [SYNC_STAGES-1:0]   sclk_sync_q, sclk_sync_d;
   logic                     din_dly_q, din_dly_d;
   logic                     ncs_dly_q, ncs_dly_d;
   logic                     sclk_dly_q, sclk_dly_d;
   state_t                   state_q, state_d;
   logic [SR_W-1:0]          sr_q, sr_d;
   logic [4:0]               cnt_q, cnt_d;
   logic [DATAWIDTH_BUS-1:0] digit_q [8];
   logic [DATAWIDTH_BUS-1:0] digit_d [8];
   logic [7:0]               decode_mode_q, decode_mode_d;
   logic [3:0]               intensity_q, intensity_d;
   logic [2:0]               scan_limit_q, scan_limit_d;
   logic                     shutdown_q, shutdown_d;
   logic                     display_test_q, display_test_d;
   logic                     frame_valid_q, frame_valid_d;
   logic                     frame_error_q, frame_error_d;
   logic [3:0]               frame_addr_q, frame_addr_d;
   logic [7:0]               frame_data_q, frame_data_d;
   logic [DATAWIDTH_BUS-1:0] rd_data_q, rd_data_d;
`ifdef SC_MAX7219RX_DOUT_EN
   logic                     dout_pend_q, dout_pend_d;
   logic                     dout_q, dout_d;
   logic                     sclk_fall_s;
`endif

   logic       ncs_s;
   logic       sclk_s;
   logic       ncs_fall_s;
   logic       ncs_rise_s;
   logic       sclk_rise_s;
   logic       shift_en_s;
   logic [2:0] row_s;

   assign ncs_s       = ncs_sync_q[SYNC_STAGES-1];
   assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
   assign ncs_fall_s  = ncs_dly_q & ~ncs_s;
   assign ncs_rise_s  = ~ncs_dly_q & ncs_s;
   assign sclk_rise_s = ~sclk_dly_q & sclk_s;
   // A clock edge coinciding with the closing ncs edge still shifts before the latch.
   assign shift_en_s  = (state_q == ST_SHIFT) && sclk_rise_s && (~ncs_s || ncs_rise_s);
   assign row_s       = frame_addr_q[2:0] - 3'd1;
`ifdef SC_MAX7219RX_DOUT_EN
   assign sclk_fall_s = sclk_dly_q & ~sclk_s;
`endif

   // Next-state logic: input conditioning, framing FSM, register decode and readback.
   always_comb begin
      din_sync_d     = {din_sync_q[SYNC_STAGES-2:0], bus.SC_MAX7219RX_din_In};
      ncs_sync_d     = {ncs_sync_q[SYNC_STAGES-2:0], bus.SC_MAX7219RX_ncs_In};
      sclk_sync_d    = {sclk_sync_q[SYNC_STAGES-2:0], bus.SC_MAX7219RX_sclk_In};
      din_dly_d      = din_sync_q[SYNC_STAGES-1];
      ncs_dly_d      = ncs_s;
      sclk_dly_d     = sclk_s;
      state_d        = state_q;
      sr_d           = sr_q;
      cnt_d          = cnt_q;
      digit_d        = digit_q;
      decode_mode_d  = decode_mode_q;
      intensity_d    = intensity_q;
      scan_limit_d   = scan_limit_q;
      shutdown_d     = shutdown_q;
      display_test_d = display_test_q;
      frame_valid_d  = 1'b0;
      frame_error_d  = 1'b0;
      frame_addr_d   = frame_addr_q;
      frame_data_d   = frame_data_q;
      rd_data_d      = digit_q[bus.SC_MAX7219RX_rdAddr_In];
`ifdef SC_MAX7219RX_DOUT_EN
      dout_pend_d    = dout_pend_q;
      dout_d         = dout_q;
`endif

      if (shift_en_s) begin
         sr_d  = {sr_q[SR_W-2:0], din_dly_q};
         cnt_d = (cnt_q == 5'd31) ? 5'd31 : (cnt_q + 5'd1);
`ifdef SC_MAX7219RX_DOUT_EN
         dout_pend_d = sr_q[SR_W-1];
`endif
      end else begin
         sr_d  = sr_q;
         cnt_d = cnt_q;
      end

`ifdef SC_MAX7219RX_DOUT_EN
      if (sclk_fall_s && ~ncs_s) begin
         dout_d = dout_pend_q;
      end else begin
         dout_d = dout_q;
      end
`endif

      case (state_q)
         ST_IDLE: begin
            if (ncs_fall_s) begin
               state_d = ST_SHIFT;
               sr_d    = '0;
               cnt_d   = 5'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (ncs_rise_s) begin
               state_d = ST_LATCH;
               if (cnt_d >= 5'(FRAME_BITS)) begin
                  frame_valid_d = 1'b1;
                  frame_addr_d  = sr_d[11:8];
                  frame_data_d  = sr_d[7:0];
               end else begin
                  frame_error_d = 1'b1;
               end
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_LATCH: begin
            state_d = ST_IDLE;
            if (frame_valid_q) begin
               case (frame_addr_q)
                  4'h1, 4'h2, 4'h3, 4'h4,
                  4'h5, 4'h6, 4'h7, 4'h8: digit_d[row_s] = DATAWIDTH_BUS'(frame_data_q);
                  4'h9:    decode_mode_d  = frame_data_q;
                  4'hA:    intensity_d    = frame_data_q[3:0];
                  4'hB:    scan_limit_d   = frame_data_q[2:0];
                  4'hC:    shutdown_d     = ~frame_data_q[0];
                  4'hF:    display_test_d = frame_data_q[0];
                  default: decode_mode_d  = decode_mode_q;
               endcase
            end else begin
               decode_mode_d = decode_mode_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; ncs chain resets low so a held-low ncs cannot open a frame.
   always_ff @(posedge SC_MAX7219RX_CLOCK_50 or posedge SC_MAX7219RX_RESET_InHigh) begin
      if (SC_MAX7219RX_RESET_InHigh) begin
         din_sync_q     <= '0;
         ncs_sync_q     <= '0;
         sclk_sync_q    <= '0;
         din_dly_q      <= 1'b0;
         ncs_dly_q      <= 1'b0;
         sclk_dly_q     <= 1'b0;
         state_q        <= ST_IDLE;
         sr_q           <= '0;
         cnt_q          <= 5'd0;
         for (int i = 0; i < 8; i++) begin
            digit_q[i] <= '0;
         end
         decode_mode_q  <= 8'd0;
         intensity_q    <= 4'd0;
         scan_limit_q   <= 3'd0;
         shutdown_q     <= 1'b1;
         display_test_q <= 1'b0;
         frame_valid_q  <= 1'b0;
         frame_error_q  <= 1'b0;
         frame_addr_q   <= 4'd0;
         frame_data_q   <= 8'd0;
         rd_data_q      <= '0;
`ifdef SC_MAX7219RX_DOUT_EN
         dout_pend_q    <= 1'b0;
         dout_q         <= 1'b0;
`endif
      end else begin
         din_sync_q     <= din_sync_d;
         ncs_sync_q     <= ncs_sync_d;
         sclk_sync_q    <= sclk_sync_d;
         din_dly_q      <= din_dly_d;
         ncs_dly_q      <= ncs_dly_d;
         sclk_dly_q     <= sclk_dly_d;
         state_q        <= state_d;
         sr_q           <= sr_d;
         cnt_q          <= cnt_d;
         digit_q        <= digit_d;
         decode_mode_q  <= decode_mode_d;
         intensity_q    <= intensity_d;
         scan_limit_q   <= scan_limit_d;
         shutdown_q     <= shutdown_d;
         display_test_q <= display_test_d;
         frame_valid_q  <= frame_valid_d;
         frame_error_q  <= frame_error_d;
         frame_addr_q   <= frame_addr_d;
         frame_data_q   <= frame_data_d;
         rd_data_q      <= rd_data_d;
`ifdef SC_MAX7219RX_DOUT_EN
         dout_pend_q    <= dout_pend_d;
         dout_q         <= dout_d;
`endif
      end
   end

   assign bus.SC_MAX7219RX_rdData_Out      = rd_data_q;
   assign bus.SC_MAX7219RX_intensity_Out   = intensity_q;
   assign bus.SC_MAX7219RX_scanLimit_Out   = scan_limit_q;
   assign bus.SC_MAX7219RX_decodeMode_Out  = decode_mode_q;
   assign bus.SC_MAX7219RX_shutdown_Out    = shutdown_q;
   assign bus.SC_MAX7219RX_displayTest_Out = display_test_q;
   assign bus.SC_MAX7219RX_frameValid_Out  = frame_valid_q;
   assign bus.SC_MAX7219RX_frameAddr_Out   = frame_addr_q;
   assign bus.SC_MAX7219RX_frameData_Out   = frame_data_q;
   assign bus.SC_MAX7219RX_frameError_Out  = frame_error_q;
`ifdef SC_MAX7219RX_DOUT_EN
   assign bus.SC_MAX7219RX_dout_Out        = dout_q;
`endif

endmodule

// File: tb/tb_sc_max7219_rx.sv
// tb_sc_max7219_rx: scoreboard bench for sc_max7219_rx; frame events are queued when
// driven and popped when the receiver pulses frameValid/frameError.
module tb_sc_max7219_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din_r = 1'b0;
   logic       ncs_r = 1'b1;
   logic       sclk_r = 1'b0;
   logic [2:0] rd_addr_r = 3'd0;

   always #10 clk = ~clk;

   sc_max7219_rx_if #(.DATAWIDTH_BUS(8)) bus_if ();

   assign bus_if.SC_MAX7219RX_din_In    = din_r;
   assign bus_if.SC_MAX7219RX_ncs_In    = ncs_r;
   assign bus_if.SC_MAX7219RX_sclk_In   = sclk_r;
   assign bus_if.SC_MAX7219RX_rdAddr_In = rd_addr_r;

   sc_max7219_rx #(.DATAWIDTH_BUS(8), .SYNC_STAGES(2), .FRAME_BITS(16)) dut (
      .SC_MAX7219RX_CLOCK_50    (clk),
      .SC_MAX7219RX_RESET_InHigh(rst),
      .bus                      (bus_if.slave)
   );

   typedef struct packed {
      logic       err;
      logic [3:0] addr;
      logic [7:0] data;
   } ev_t;

   ev_t        exp_q [$];
   ev_t        ev_r;
   int         n_checks = 0;
   int         n_errs = 0;
   logic [7:0] m_digit [8];
   logic [7:0] m_decode;
   logic [3:0] m_int;
   logic [2:0] m_scan;
   logic       m_shut;
   logic       m_test;
   logic [3:0] m_faddr;
   logic [7:0] m_fdata;
   logic [7:0] loss [8] = '{8'h00, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h00};

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
      m_decode = 8'h00; m_int = 4'h0; m_scan = 3'd0; m_shut = 1'b1; m_test = 1'b0;
      m_faddr = 4'h0; m_fdata = 8'h00;
   endtask

   // Reference decode: only the last 16 shifted bits count, fewer than 16 is an error.
   task automatic model_frame(input logic [31:0] w, input int n);
      ev_t e;
      if (n < 16) begin
         e.err = 1'b1; e.addr = 4'h0; e.data = 8'h00;
      end else begin
         e.err = 1'b0; e.addr = w[11:8]; e.data = w[7:0];
         m_faddr = e.addr; m_fdata = e.data;
         case (e.addr)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: m_digit[e.addr - 4'h1] = e.data;
            4'h9: m_decode = e.data;
            4'hA: m_int = e.data[3:0];
            4'hB: m_scan = e.data[2:0];
            4'hC: m_shut = ~e.data[0];
            4'hF: m_test = e.data[0];
            default: ;
         endcase
      end
      exp_q.push_back(e);
   endtask

   // Scoreboard consumer: every pulse must match the oldest queued event.
   always @(negedge clk) begin
      if (!rst && (bus_if.SC_MAX7219RX_frameValid_Out || bus_if.SC_MAX7219RX_frameError_Out)) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_event", {30'd0, bus_if.SC_MAX7219RX_frameValid_Out,
                     bus_if.SC_MAX7219RX_frameError_Out}, 32'd0);
         end else begin
            ev_r = exp_q.pop_front();
            check_eq("event_kind", {30'd0, bus_if.SC_MAX7219RX_frameValid_Out,
                     bus_if.SC_MAX7219RX_frameError_Out}, {30'd0, ~ev_r.err, ev_r.err});
            if (!ev_r.err) begin
               check_eq("frame_addr", {28'd0, bus_if.SC_MAX7219RX_frameAddr_Out}, {28'd0, ev_r.addr});
               check_eq("frame_data", {24'd0, bus_if.SC_MAX7219RX_frameData_Out}, {24'd0, ev_r.data});
            end
         end
      end
   end

   task automatic clock_bit(input logic b, input bit close_ncs);
      din_r = b;
      repeat (4) @(negedge clk);
      sclk_r = 1'b1;
      if (close_ncs) ncs_r = 1'b1;
      repeat (4) @(negedge clk);
      sclk_r = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic send_frame(input logic [31:0] w, input int n, input bit merge);
      @(negedge clk);
      ncs_r = 1'b0;
      repeat (4) @(negedge clk);
      for (int k = 0; k < n; k++) begin
         clock_bit(w[n-1-k], merge && (k == n - 1));
`ifdef SC_MAX7219RX_DOUT_EN
         if (k >= 16) check_eq("dout", {31'd0, bus_if.SC_MAX7219RX_dout_Out}, {31'd0, w[n-1-(k-16)]});
`endif
      end
      ncs_r = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
      check_eq("drain", exp_q.size(), 32'd0);
   endtask

   task automatic check_regs();
      check_eq("intensity", {28'd0, bus_if.SC_MAX7219RX_intensity_Out}, {28'd0, m_int});
      check_eq("scan_limit", {29'd0, bus_if.SC_MAX7219RX_scanLimit_Out}, {29'd0, m_scan});
      check_eq("decode_mode", {24'd0, bus_if.SC_MAX7219RX_decodeMode_Out}, {24'd0, m_decode});
      check_eq("shutdown", {31'd0, bus_if.SC_MAX7219RX_shutdown_Out}, {31'd0, m_shut});
      check_eq("display_test", {31'd0, bus_if.SC_MAX7219RX_displayTest_Out}, {31'd0, m_test});
      check_eq("last_addr", {28'd0, bus_if.SC_MAX7219RX_frameAddr_Out}, {28'd0, m_faddr});
      check_eq("last_data", {24'd0, bus_if.SC_MAX7219RX_frameData_Out}, {24'd0, m_fdata});
      @(negedge clk);
      rd_addr_r = 3'd0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_eq("rd_data", {24'd0, bus_if.SC_MAX7219RX_rdData_Out}, {24'd0, m_digit[i]});
         if (i < 7) begin
            rd_addr_r = 3'(i + 1);
            #1;
            check_eq("rd_latency", {24'd0, bus_if.SC_MAX7219RX_rdData_Out}, {24'd0, m_digit[i]});
         end
      end
   endtask

   initial begin
      model_reset();
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check_regs();

      model_frame(32'h0C01, 16); send_frame(32'h0C01, 16, 1'b0);
      model_frame(32'h0A0A, 16); send_frame(32'h0A0A, 16, 1'b0);
      wait_drain(); check_regs();

      for (int i = 0; i < 8; i++) begin
         model_frame({20'd0, 4'(i + 1), loss[i]}, 16);
         send_frame({20'd0, 4'(i + 1), loss[i]}, 16, 1'b0);
      end
      wait_drain(); check_regs();

      model_frame(32'h09A5, 16); send_frame(32'h09A5, 16, 1'b0);
      model_frame(32'h0000, 16); send_frame(32'h0000, 16, 1'b0);
      model_frame(32'h0D77, 16); send_frame(32'h0D77, 16, 1'b0);
      model_frame(32'h0F01, 16); send_frame(32'h0F01, 16, 1'b1);
      wait_drain(); check_regs();

      model_frame(32'h0C00, 12); send_frame(32'h0C00, 12, 1'b0);
      wait_drain(); check_regs();
      model_frame(32'h50B07, 20); send_frame(32'h50B07, 20, 1'b0);
      wait_drain(); check_regs();

      // Serial clock activity with ncs high must be invisible.
      for (int i = 0; i < 10; i++) begin
         din_r = 1'($urandom_range(1, 0));
         repeat (3) @(negedge clk);
         sclk_r = 1'b1;
         repeat (3) @(negedge clk);
         sclk_r = 1'b0;
      end
      repeat (8) @(negedge clk);
      check_regs();

      // Reset lands after the first byte of 0x0301; the rest of the frame must be dropped.
      @(negedge clk);
      ncs_r = 1'b0;
      repeat (4) @(negedge clk);
      for (int k = 15; k >= 8; k--) clock_bit(1'(32'h0301 >> k), 1'b0);
      rst = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int k = 7; k >= 0; k--) clock_bit(1'(32'h0301 >> k), 1'b0);
      ncs_r = 1'b1;
      repeat (10) @(negedge clk);
      check_regs();
      model_frame(32'h0305, 16); send_frame(32'h0305, 16, 1'b0);
      wait_drain(); check_regs();

      model_frame(32'h015502AA, 32); send_frame(32'h015502AA, 32, 1'b0);
      wait_drain(); check_regs();

      check_eq("queue_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
